// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control unit:
// opcodes, FSM states, ALUOp/ALUSrcB/PCSource codes and the control word.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } aluop_t;

  typedef enum logic [1:0] {
    SRCB_REG  = 2'b00,
    SRCB_FOUR = 2'b01,
    SRCB_IMM  = 2'b10,
    SRCB_IMM4 = 2'b11
  } srcb_t;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10
  } pcsrc_t;

  typedef struct packed {
    logic   pcwrite;
    logic   pcwritecond;
    logic   iord;
    logic   memread;
    logic   memwrite;
    logic   irwrite;
    logic   memtoreg;
    logic   regwrite;
    logic   regdst;
    logic   alusrca;
    srcb_t  alusrcb;
    pcsrc_t pcsource;
    aluop_t aluop;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) ||
           (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// Combinational state -> control word decode (Moore part of the FSM).
// Ports: st (state code in), cw (control word out; 12-15 decode to 0).
module ctrl_output_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] st,
  output ctrl_t      cw
);

  always_comb begin
    cw = '0;
    case (st)
      S_FETCH: begin
        cw.memread = 1'b1;
        cw.alusrcb = SRCB_FOUR;
        cw.pcwrite = 1'b1;
        cw.irwrite = 1'b1;
      end
      S_DECODE: begin
        cw.alusrcb = SRCB_IMM4;
      end
      S_MEM_ADDR: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_IMM;
      end
      S_MEM_READ: begin
        cw.memread = 1'b1;
        cw.iord    = 1'b1;
      end
      S_MEM_WB: begin
        cw.regwrite = 1'b1;
        cw.memtoreg = 1'b1;
      end
      S_MEM_WRITE: begin
        cw.memwrite = 1'b1;
        cw.iord     = 1'b1;
      end
      S_EXECUTE: begin
        cw.alusrca = 1'b1;
        cw.aluop   = ALU_FUNCT;
      end
      S_R_WB: begin
        cw.regwrite = 1'b1;
        cw.regdst   = 1'b1;
      end
      S_BRANCH: begin
        cw.alusrca     = 1'b1;
        cw.aluop       = ALU_SUB;
        cw.pcwritecond = 1'b1;
        cw.pcsource    = PC_ALUOUT;
      end
      S_JUMP: begin
        cw.pcwrite  = 1'b1;
        cw.pcsource = PC_JUMP;
      end
      S_ADDI_EXEC: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_IMM;
      end
      S_ADDI_WB: begin
        cw.regwrite = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/main_control_fsm.sv
// Multi-cycle MIPS main control FSM: state register, next state, mem_ready gating.
// Ports: clk, reset (sync, high), Op, mem_ready in; datapath strobes, ALUOp, illegal_op, state out.
module main_control_fsm
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t st;
  ctrl_t  cw;
  logic   run;
  logic   gate;

  always_ff @(posedge clk) begin
    if (reset) begin
      st <= S_FETCH;
    end else begin
      case (st)
        S_FETCH:
          if (mem_ready) st <= S_DECODE;
        S_DECODE:
          case (Op)
            OP_LW, OP_SW: st <= S_MEM_ADDR;
            OP_RTYPE:     st <= S_EXECUTE;
            OP_BEQ:       st <= S_BRANCH;
            OP_J:         st <= S_JUMP;
            OP_ADDI:      st <= S_ADDI_EXEC;
            default:      st <= S_FETCH;
          endcase
        S_MEM_ADDR:
          if (Op == OP_LW)      st <= S_MEM_READ;
          else if (Op == OP_SW) st <= S_MEM_WRITE;
          else                  st <= S_FETCH;
        S_MEM_READ:
          if (mem_ready) st <= S_MEM_WB;
        S_MEM_WRITE:
          if (mem_ready) st <= S_FETCH;
        S_EXECUTE:   st <= S_R_WB;
        S_ADDI_EXEC: st <= S_ADDI_WB;
        default:     st <= S_FETCH;
      endcase
    end
  end

  ctrl_output_decode u_dec (
    .st (st),
    .cw (cw)
  );

  // Reset forces every output low, so an abandoned
  // instruction can never strobe a write.
  assign run  = ~reset;
  // PC/IR updates in FETCH wait for the instruction word.
  assign gate = (st != S_FETCH) | mem_ready;

  assign PCWrite     = run & cw.pcwrite & gate;
  assign IRWrite     = run & cw.irwrite & gate;
  assign PCWriteCond = run & cw.pcwritecond;
  assign IorD        = run & cw.iord;
  assign MemRead     = run & cw.memread;
  assign MemWrite    = run & cw.memwrite;
  assign MemtoReg    = run & cw.memtoreg;
  assign RegWrite    = run & cw.regwrite;
  assign RegDst      = run & cw.regdst;
  assign ALUSrcA     = run & cw.alusrca;
  assign ALUSrcB     = run ? cw.alusrcb : 2'b00;
  assign PCSource    = run ? cw.pcsource : 2'b00;
  assign ALUOp       = run ? cw.aluop : 2'b00;
  assign illegal_op  = run & (st == S_DECODE) & ~op_legal(Op);
  assign state       = run ? st : 4'd0;

endmodule

// File: tb/tb_main_control_fsm.sv
// Self-checking bench for main_control_fsm: queue-based instruction model,
// per-cycle compare, directed traces and randomized stimulus.
module tb_main_control_fsm;

  logic       clk;
  logic       reset;
  logic [5:0] Op;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegWrite, RegDst, ALUSrcA, illegal_op;
  logic [1:0] ALUSrcB, PCSource, ALUOp;
  logic [3:0] state;

  main_control_fsm dut (
    .clk         (clk),
    .reset       (reset),
    .Op          (Op),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegWrite    (RegWrite),
    .RegDst      (RegDst),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .PCSource    (PCSource),
    .ALUOp       (ALUOp),
    .illegal_op  (illegal_op),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // obs bit map: 16 PCWrite,15 PCWriteCond,14 IorD,13 MemRead,12 MemWrite,
  // 11 IRWrite,10 MemtoReg,9 RegWrite,8 RegDst,7 ALUSrcA,6:5 SrcB,4:3 PCSrc,2:1 ALUOp,0 ill
  logic [16:0] obs;
  assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, RegWrite, RegDst, ALUSrcA, ALUSrcB, PCSource,
                ALUOp, illegal_op};

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Model: current state number plus queue of states still to visit
  int cur = 0;
  int pend[$];
  logic [5:0] inst_op = 6'h23;

  logic [3:0]  tr_st[$];
  logic [16:0] tr_ob[$];

  function automatic logic legal(input logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h08};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  function automatic logic [20:0] expect_out(input logic r,
      input logic [5:0] op, input logic mr);
    logic pcw, pcc, iord, mrd, mwr, irw, m2r, rw, rd, sa, ill;
    logic [1:0] sb, ps, ao;
    {pcw, pcc, iord, mrd, mwr, irw, m2r, rw, rd, sa, ill} = '0;
    sb = 2'b00; ps = 2'b00; ao = 2'b00;
    if (r) return '0;
    case (cur)
      0: begin mrd = 1; sb = 2'b01; pcw = mr; irw = mr; end
      1: begin sb = 2'b11; ill = !legal(op); end
      2: begin sa = 1; sb = 2'b10; end
      3: begin mrd = 1; iord = 1; end
      4: begin rw = 1; m2r = 1; end
      5: begin mwr = 1; iord = 1; end
      6: begin sa = 1; ao = 2'b10; end
      7: begin rw = 1; rd = 1; end
      8: begin sa = 1; ao = 2'b01; pcc = 1; ps = 2'b01; end
      9: begin pcw = 1; ps = 2'b10; end
      10: begin sa = 1; sb = 2'b10; end
      11: begin rw = 1; end
      default: ;
    endcase
    return {4'(cur), pcw, pcc, iord, mrd, mwr, irw, m2r, rw, rd, sa,
            sb, ps, ao, ill};
  endfunction

  task automatic model_step(input logic r, input logic [5:0] op,
                            input logic mr);
    logic adv;
    adv = 1'b1;
    if (r) begin
      cur = 0;
      pend.delete();
      return;
    end
    case (cur)
      0: adv = mr;
      1: begin
        pend.delete();
        if (op == 6'h23) pend = '{2, 3, 4};
        else if (op == 6'h2b) pend = '{2, 5};
        else if (op == 6'h00) pend = '{6, 7};
        else if (op == 6'h04) pend = '{8};
        else if (op == 6'h02) pend = '{9};
        else if (op == 6'h08) pend = '{10, 11};
      end
      3, 5: adv = mr;
      default: ;
    endcase
    if (adv) begin
      if (cur == 0) cur = 1;
      else if (pend.size() > 0) cur = pend.pop_front();
      else cur = 0;
    end
  endtask

  task automatic step(input logic r, input logic [5:0] op, input logic mr);
    reset = r;
    Op = op;
    mem_ready = mr;
    #4;
    chk($sformatf("cyc%0d_ctrl", cyc), {11'd0, state, obs},
        {11'd0, expect_out(r, op, mr)});
    tr_st.push_back(state);
    tr_ob.push_back(obs);
    @(posedge clk);
    model_step(r, op, mr);
    cyc++;
    #1;
  endtask

  task automatic seq(input logic [5:0] op, input int n,
                     input logic [15:0] mrs);
    tr_st.delete();
    tr_ob.delete();
    for (int i = 0; i < n; i++) step(1'b0, op, mrs[i]);
  endtask

  task automatic trace_chk(input string nm, input int n,
                           input logic [63:0] ex);
    if (tr_st.size() < n) begin
      chk({nm, "_len"}, tr_st.size(), n);
      return;
    end
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_st%0d", nm, i), tr_st[i], ex[4*(n-1-i) +: 4]);
  endtask

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 6))
      0: return 6'h00;
      1: return 6'h23;
      2: return 6'h2b;
      3: return 6'h04;
      4: return 6'h02;
      5: return 6'h08;
      default: return 6'($urandom);
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    Op = 6'h23;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;

    // reset held 3 cycles with Op=lw
    tr_ob.delete();
    for (int i = 0; i < 3; i++) step(1'b1, 6'h23, i[0]);
    for (int i = 0; i < 3; i++)
      chk($sformatf("rst_zero%0d", i), tr_ob[i], 0);

    // lw, then fetch of next instruction stalls
    seq(6'h23, 6, 16'b011111);
    trace_chk("lw", 6, 64'h012340);
    chk("rel_memread", tr_ob[0][13], 1);
    chk("rel_srcb", tr_ob[0][6:5], 2'b01);
    chk("rel_pcwrite", tr_ob[0][16], 1);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("lw_rw%0d", i), tr_ob[i][9], i == 4);
      chk($sformatf("lw_m2r%0d", i), tr_ob[i][10], i == 4);
    end

    seq(6'h00, 5, 16'b01111);
    trace_chk("rtype", 5, 64'h01670);
    chk("r_aluop", tr_ob[2][2:1], 2'b10);
    chk("r_rw", tr_ob[3][9], 1);
    chk("r_rd", tr_ob[3][8], 1);

    seq(6'h04, 4, 16'b0111);
    trace_chk("beq", 4, 64'h0180);
    chk("beq_aluop", tr_ob[2][2:1], 2'b01);
    chk("beq_pcc", tr_ob[2][15], 1);
    chk("beq_pcsrc", tr_ob[2][4:3], 2'b01);

    seq(6'h02, 4, 16'b0111);
    trace_chk("j", 4, 64'h0190);
    chk("j_pcw", tr_ob[2][16], 1);
    chk("j_pcsrc", tr_ob[2][4:3], 2'b10);

    // sw with 2 stall cycles in FETCH and MEM_WRITE: 8 cycles
    seq(6'h2b, 9, 16'b010011100);
    trace_chk("sw", 9, 64'h000125550);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("sw_stall_pcw%0d", i), tr_ob[i][16], 0);
      chk($sformatf("sw_stall_irw%0d", i), tr_ob[i][11], 0);
      chk($sformatf("sw_stall_mrd%0d", i), tr_ob[i][13], 1);
    end
    for (int i = 5; i < 8; i++)
      chk($sformatf("sw_mw%0d", i), tr_ob[i][12], 1);

    seq(6'h3f, 3, 16'b011);
    trace_chk("ill", 3, 64'h010);
    for (int i = 0; i < 3; i++)
      chk($sformatf("ill_pulse%0d", i), tr_ob[i][0], i == 1);

    // reset while lw stalls in MEM_READ
    seq(6'h23, 4, 16'b0111);
    step(1'b1, 6'h23, 1'b1);
    step(1'b0, 6'h23, 1'b0);
    trace_chk("rstmid", 6, 64'h012300);
    chk("rstmid_rw", tr_ob[4][9], 0);
    chk("rstmid_zero", tr_ob[4], 0);
    chk("rstmid_fetch", tr_ob[5][13], 1);

    // randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      logic r;
      logic mr;
      logic [5:0] op;
      r = ($urandom_range(0, 63) == 0);
      mr = ($urandom_range(0, 3) != 0);
      if (cur == 0) inst_op = pick_op();
      op = (cur == 1 || cur == 2) ? inst_op : 6'($urandom);
      step(r, op, mr);
      if (tr_st.size() > 16) begin
        tr_st.delete();
        tr_ob.delete();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/main_control_fsm.md
# main_control_fsm

Multi-cycle MIPS main control unit, directly upstream of the ALU control decoder. Sequences each instruction through fetch, decode, execute, memory and write-back states from the 6-bit opcode. Drives the datapath strobes and the 2-bit `ALUOp` that the ALU control decoder expands, together with `Funct`, into the 4-bit ALU operation. Stalls on a memory-ready handshake.

## Interface
Parameters:
- none. All encodings are fixed constants in `mips_ctrl_pkg`.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `Op`  in  6  opcode, `IR[31:26]`, valid from the DECODE cycle onward.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `MemtoReg`, `RegWrite`, `RegDst`, `ALUSrcA`  out  1 each  datapath controls.
- `ALUSrcB`  out  2  operand B select: 00 = B, 01 = const 4, 10 = sext imm, 11 = sext imm<<2.
- `PCSource`  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `ALUOp`  out  2  to ALU control: 00 = add, 01 = sub, 10 = use Funct.
- `illegal_op`  out  1  one-cycle pulse on an unrecognised opcode.
- `state`  out  4  current state, for debug and tracing.

## Operation
- Moore FSM with a 4-bit state register. The only Mealy terms are the `mem_ready` qualifiers on `PCWrite` and `IRWrite`.
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- Any output not listed for a state is 0.

States, their outputs, and transitions:
- FETCH (0)
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=PCWrite=mem_ready.
  - Next: stay while !mem_ready, else DECODE.
- DECODE (1)
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - Next: lw/sw→MEM_ADDR, R→EXECUTE, beq→BRANCH, j→JUMP, addi→ADDI_EXEC.
  - Any other opcode: go to FETCH and set illegal_op=1.
- MEM_ADDR (2)
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Next: lw→MEM_READ, sw→MEM_WRITE.
- MEM_READ (3)
  - Outputs: MemRead=1, IorD=1.
  - Next: stay while !mem_ready, else MEM_WB.
- MEM_WB (4)
  - Outputs: RegWrite=1, MemtoReg=1, RegDst=0.
  - Next: FETCH.
- MEM_WRITE (5)
  - Outputs: MemWrite=1, IorD=1.
  - Next: stay while !mem_ready, else FETCH.
- EXECUTE (6)
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - Next: R_WB.
- R_WB (7)
  - Outputs: RegWrite=1, RegDst=1, MemtoReg=0.
  - Next: FETCH.
- BRANCH (8)
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
  - Next: FETCH.
- JUMP (9)
  - Outputs: PCWrite=1, PCSource=10.
  - Next: FETCH.
- ADDI_EXEC (10)
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Next: ADDI_WB.
- ADDI_WB (11)
  - Outputs: RegWrite=1, RegDst=0, MemtoReg=0.
  - Next: FETCH.
- Encodings 12–15: all outputs 0; next state is FETCH.

Boundary behaviour:
- `Op` is sampled only in DECODE and MEM_ADDR. `Op` changes in any other state have no effect.
- `mem_ready` is ignored outside FETCH, MEM_READ and MEM_WRITE.
- A stalled FETCH holds MemRead=1 and keeps PCWrite=IRWrite=0 until `mem_ready` is high.

## Timing
- `reset` high at a rising edge: state ← FETCH.
- While `reset` is high, all outputs are forced to 0, including `illegal_op`. `state` reads 0.
- `reset` asserted mid-instruction abandons that instruction. No write strobe may assert in the reset cycle.
- First cycle after `reset` falls: FETCH outputs are active.
- Cycles per instruction, with `mem_ready` tied high:
  - lw: 5
  - sw, R-type, addi: 4
  - beq, j: 3
  - illegal opcode: 2
- Each cycle with `mem_ready` low in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- Outputs change only after a rising edge, except the `mem_ready` qualifier in FETCH.

## Structure
- `mips_ctrl_pkg` holds:
  - opcode constants;
  - the state enum (4-bit, values as listed above);
  - `ALUOp`, `ALUSrcB` and `PCSource` encodings. The ALU control decoder uses the same `ALUOp` constants.
- One sub-module, `ctrl_output_decode`: combinational state → control word.
- The top level holds the state register, the next-state logic and the `mem_ready` gating.

## Test plan
- Reset: hold `reset` 3 cycles with `Op`=100011 → all outputs 0. Release → FETCH with MemRead=1, ALUSrcB=01, PCWrite=1.
- lw with `mem_ready`=1: `state` sequence 0,1,2,3,4,0. RegWrite=1 and MemtoReg=1 only in state 4.
- R-type: `Op`=000000 → ALUOp=10 in state 6, then RegWrite=1 and RegDst=1 in state 7. Total 4 cycles.
- beq and j:
  - beq → state 8 with ALUOp=01, PCWriteCond=1, PCSource=01.
  - j → state 9 with PCWrite=1, PCSource=10.
  - Both return to FETCH after 3 cycles.
- Stalls: sw with `mem_ready` low for 2 cycles in both FETCH and MEM_WRITE.
  - FETCH: PCWrite=IRWrite=0 while stalled.
  - MEM_WRITE: MemWrite=1 held 3 cycles.
  - Total 8 cycles.
- Illegal opcode and reset mid-instruction:
  - `Op`=111111 → illegal_op=1 for exactly one cycle (DECODE), then FETCH.
  - `reset` in MEM_READ → no RegWrite, restart in FETCH.
